// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock stream monitor.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLOCKED = 2'd2
  } dl_state_e;

  // Default axis count. Child j reports as culprit index N_AXIS+j, directly after the axis lines.
  localparam int unsigned DL_SUB_OFFSET = 8;

  function automatic int unsigned dl_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while (r < 31 && (32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module hls_deadlock_prio_enc #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [W-1:0]     bits,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |bits;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = W; i > 0; i--) begin
      if (bits[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/hls_deadlock_stream_monitor.sv
// Deadlock monitor for one HLS process: filters stall/block lines, raises block after a hold time.
module hls_deadlock_stream_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned       N_AXIS      = DL_SUB_OFFSET,
  parameter logic [N_AXIS-1:0] AXIS_MASK   = N_AXIS'(8'h06),
  parameter int unsigned       N_SUB       = 4,
  parameter int unsigned       PAR_MODE    = 0,
  parameter int unsigned       HOLD_CYCLES = 1,
  parameter int unsigned       STICKY      = 0,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       CH_W        = dl_clog2(N_AXIS + N_SUB)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_SUB-1:0]  sub_idle_sigs,
  input  logic [N_SUB-1:0]  sub_block_sigs,
  output logic              block,
  output logic              block_pending,
  output logic [CH_W-1:0]   first_chan,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned HC_W  = dl_clog2(HOLD_CYCLES + 1);
  localparam int unsigned AX_IW = (N_AXIS > 1) ? dl_clog2(N_AXIS) : 1;
  localparam int unsigned SB_IW = (N_SUB > 1) ? dl_clog2(N_SUB) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  dl_state_e         state_q, state_d;
  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [CH_W-1:0]   first_chan_q, first_chan_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              block_q, block_d;
  logic              block_pending_q, block_pending_d;

  logic [N_AXIS-1:0] axis_masked;
  logic [AX_IW-1:0]  axis_idx;
  logic [SB_IW-1:0]  sub_idx;
  logic              axis_hit, sub_any, sub_hit, raw;
  logic [CH_W-1:0]   chan_sel;

  assign axis_masked = axis_block_sigs & AXIS_MASK;

  hls_deadlock_prio_enc #(.W(N_AXIS), .IDX_W(AX_IW)) u_axis_enc (
    .bits  (axis_masked),
    .idx   (axis_idx),
    .valid (axis_hit)
  );

  hls_deadlock_prio_enc #(.W(N_SUB), .IDX_W(SB_IW)) u_sub_enc (
    .bits  (sub_block_sigs),
    .idx   (sub_idx),
    .valid (sub_any)
  );

  always_comb begin
    if (PAR_MODE != 0) sub_hit = (&(sub_block_sigs | sub_idle_sigs)) & sub_any;
    else               sub_hit = sub_any;
    raw      = axis_hit | sub_hit;
    chan_sel = axis_hit ? CH_W'(axis_idx) : CH_W'(N_AXIS + 32'(sub_idx));
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    first_chan_d = first_chan_q;
    unique case (state_q)
      IDLE: begin
        if (raw) begin
          first_chan_d = chan_sel;
          if (HOLD_CYCLES == 1) begin
            state_d = BLOCKED;
          end else begin
            state_d = PENDING;
            hcnt_d  = HC_W'(1);
          end
        end
      end
      PENDING: begin
        if (!raw) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = BLOCKED;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      BLOCKED: begin
        if (!raw && STICKY == 0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase

    block_d         = (state_d == BLOCKED);
    block_pending_d = (state_d == PENDING);

    stall_count_d = stall_count_q;
    if (state_q == BLOCKED && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      hcnt_q          <= '0;
      first_chan_q    <= '0;
      stall_count_q   <= '0;
      block_q         <= 1'b0;
      block_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hcnt_q          <= hcnt_d;
      first_chan_q    <= first_chan_d;
      stall_count_q   <= stall_count_d;
      block_q         <= block_d;
      block_pending_q <= block_pending_d;
    end
  end

  assign block         = block_q;
  assign block_pending = block_pending_q;
  assign first_chan    = first_chan_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_hls_deadlock_stream_monitor.sv
// Directed bench for hls_deadlock_stream_monitor across four parameter sets.
module tb_hls_deadlock_stream_monitor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  // a: HOLD_CYCLES=4, b: defaults, c: PAR_MODE=1, d: STICKY=1 with 4-bit counter
  logic [7:0]  ax_a = '0, ax_b = '0, ax_c = '0, ax_d = '0;
  logic [3:0]  si_a = '0, si_b = '0, si_c = '0, si_d = '0;
  logic [3:0]  sb_a = '0, sb_b = '0, sb_c = '0, sb_d = '0;
  logic        blk_a, blk_b, blk_c, blk_d;
  logic        pnd_a, pnd_b, pnd_c, pnd_d;
  logic [3:0]  fc_a, fc_b, fc_c, fc_d;
  logic [15:0] sc_a, sc_b, sc_c;
  logic [3:0]  sc_d;

  hls_deadlock_stream_monitor #(.HOLD_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(ax_a), .sub_idle_sigs(si_a),
    .sub_block_sigs(sb_a), .block(blk_a), .block_pending(pnd_a),
    .first_chan(fc_a), .stall_count(sc_a));

  hls_deadlock_stream_monitor dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(ax_b), .sub_idle_sigs(si_b),
    .sub_block_sigs(sb_b), .block(blk_b), .block_pending(pnd_b),
    .first_chan(fc_b), .stall_count(sc_b));

  hls_deadlock_stream_monitor #(.PAR_MODE(1), .N_SUB(4)) dut_c (
    .clock(clock), .reset(reset), .axis_block_sigs(ax_c), .sub_idle_sigs(si_c),
    .sub_block_sigs(sb_c), .block(blk_c), .block_pending(pnd_c),
    .first_chan(fc_c), .stall_count(sc_c));

  hls_deadlock_stream_monitor #(.STICKY(1), .CNT_W(4)) dut_d (
    .clock(clock), .reset(reset), .axis_block_sigs(ax_d), .sub_idle_sigs(si_d),
    .sub_block_sigs(sb_d), .block(blk_d), .block_pending(pnd_d),
    .first_chan(fc_d), .stall_count(sc_d));

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({blk_a, pnd_a, fc_a, sc_a} !== 22'd0)
      $display("FAIL reset_a: got %b/%b/%0d/%0d want 0/0/0/0", blk_a, pnd_a, fc_a, sc_a);
    else pass_cnt++;
    total_cnt++;
    if ({blk_b, pnd_b, fc_b, sc_b} !== 22'd0)
      $display("FAIL reset_b: got %b/%b/%0d/%0d want 0/0/0/0", blk_b, pnd_b, fc_b, sc_b);
    else pass_cnt++;
    total_cnt++;
    if ({blk_c, pnd_c, fc_c, sc_c} !== 22'd0)
      $display("FAIL reset_c: got %b/%b/%0d/%0d want 0/0/0/0", blk_c, pnd_c, fc_c, sc_c);
    else pass_cnt++;
    total_cnt++;
    if ({blk_d, pnd_d, fc_d, sc_d} !== 10'd0)
      $display("FAIL reset_d: got %b/%b/%0d/%0d want 0/0/0/0", blk_d, pnd_d, fc_d, sc_d);
    else pass_cnt++;
  endtask

  task automatic test_hold_filter();
    for (int t = 0; t <= 7; t++) begin
      @(posedge clock); #1;
      ax_a = (t <= 5) ? 8'h04 : 8'h00;
      @(negedge clock);
      total_cnt++;
      if (pnd_a !== (t >= 1 && t <= 3))
        $display("FAIL hold_pending t%0d: got %b want %b", t, pnd_a, (t >= 1 && t <= 3));
      else pass_cnt++;
      total_cnt++;
      if (blk_a !== (t >= 4 && t <= 6))
        $display("FAIL hold_block t%0d: got %b want %b", t, blk_a, (t >= 4 && t <= 6));
      else pass_cnt++;
      if (t == 4) begin
        total_cnt++;
        if (fc_a !== 4'd2) $display("FAIL hold_first_chan: got %0d want 2", fc_a);
        else pass_cnt++;
      end
      if (t == 5) begin
        total_cnt++;
        if (sc_a !== 16'd1) $display("FAIL hold_stall_t5: got %0d want 1", sc_a);
        else pass_cnt++;
      end
      if (t == 7) begin
        total_cnt++;
        if (sc_a !== 16'd3) $display("FAIL hold_stall_t7: got %0d want 3", sc_a);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_unmasked();
    for (int t = 0; t < 10; t++) begin
      @(posedge clock); #1;
      ax_b = 8'h01;
      @(negedge clock);
      total_cnt++;
      if ({blk_b, pnd_b, fc_b} !== 6'd0)
        $display("FAIL unmasked t%0d: got %b/%b/%0d want 0/0/0", t, blk_b, pnd_b, fc_b);
      else pass_cnt++;
    end
    @(posedge clock); #1 ax_b = 8'h00;
  endtask

  task automatic test_legacy_latency();
    // onset with two watched lines: lowest index wins, block one cycle later
    @(posedge clock); #1 ax_b = 8'h06;
    @(negedge clock);
    total_cnt++;
    if (blk_b !== 1'b0) $display("FAIL legacy_t0: got %b want 0", blk_b);
    else pass_cnt++;
    @(posedge clock); #1 ax_b = 8'h00;
    @(negedge clock);
    total_cnt++;
    if (blk_b !== 1'b1 || fc_b !== 4'd1)
      $display("FAIL legacy_t1: got %b/%0d want 1/1", blk_b, fc_b);
    else pass_cnt++;
    // child onset reports N_AXIS+j
    @(posedge clock); #1 sb_b = 4'b0010;
    @(negedge clock);
    total_cnt++;
    if (blk_b !== 1'b0) $display("FAIL legacy_deassert: got %b want 0", blk_b);
    else pass_cnt++;
    @(posedge clock); #1 sb_b = 4'b0000;
    @(negedge clock);
    total_cnt++;
    if (blk_b !== 1'b1 || fc_b !== 4'd9)
      $display("FAIL legacy_child: got %b/%0d want 1/9", blk_b, fc_b);
    else pass_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_dropout();
    logic [8:0] pat;
    pat = 9'b111110111; // bit t is raw at cycle t
    for (int t = 0; t <= 8; t++) begin
      @(posedge clock); #1;
      ax_a = pat[t] ? 8'h02 : 8'h00;
      @(negedge clock);
      total_cnt++;
      if (blk_a !== (t == 8)) $display("FAIL dropout_block t%0d: got %b want %b", t, blk_a, (t == 8));
      else pass_cnt++;
    end
    total_cnt++;
    if (fc_a !== 4'd1) $display("FAIL dropout_first_chan: got %0d want 1", fc_a);
    else pass_cnt++;
    @(posedge clock); #1 ax_a = 8'h00;
    @(posedge clock); #1;
  endtask

  task automatic test_par_mode();
    si_c = 4'b0011;
    @(posedge clock); #1 sb_c = 4'b0100;
    @(posedge clock); #1;
    @(negedge clock);
    total_cnt++;
    if (blk_c !== 1'b0) $display("FAIL par_partial: got %b want 0", blk_c);
    else pass_cnt++;
    @(posedge clock); #1 sb_c = 4'b1100;
    @(negedge clock);
    total_cnt++;
    if (blk_c !== 1'b0) $display("FAIL par_before_edge: got %b want 0", blk_c);
    else pass_cnt++;
    @(posedge clock); #1;
    @(negedge clock);
    total_cnt++;
    if (blk_c !== 1'b1 || fc_c !== 4'd10 || pnd_c !== 1'b0)
      $display("FAIL par_all: got %b/%0d/%b want 1/10/0", blk_c, fc_c, pnd_c);
    else pass_cnt++;
  endtask

  task automatic test_sticky();
    for (int t = 0; t <= 20; t++) begin
      @(posedge clock); #1;
      ax_d = (t == 0) ? 8'h04 : 8'h00;
      @(negedge clock);
      if (t == 1 || t == 5 || t == 20) begin
        total_cnt++;
        if (blk_d !== 1'b1) $display("FAIL sticky_block t%0d: got %b want 1", t, blk_d);
        else pass_cnt++;
      end
      if (t == 2 || t == 10 || t == 16 || t == 20) begin
        total_cnt++;
        if (sc_d !== ((t >= 16) ? 4'd15 : 4'(t - 1)))
          $display("FAIL sticky_count t%0d: got %0d want %0d", t, sc_d,
                   (t >= 16) ? 15 : t - 1);
        else pass_cnt++;
      end
    end
    // pend dut_a mid-filter so reset also clears a PENDING instance
    @(posedge clock); #1 ax_a = 8'h04;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if (pnd_a !== 1'b1) $display("FAIL pre_reset_pending: got %b want 1", pnd_a);
    else pass_cnt++;
    @(posedge clock); #1 reset = 1'b0; ax_a = 8'h00;
    @(negedge clock);
    total_cnt++;
    if ({blk_d, pnd_d, fc_d, sc_d} !== 10'd0)
      $display("FAIL sticky_reset: got %b/%b/%0d/%0d want 0/0/0/0", blk_d, pnd_d, fc_d, sc_d);
    else pass_cnt++;
    total_cnt++;
    if ({blk_a, pnd_a, fc_a, sc_a} !== 22'd0)
      $display("FAIL pending_reset: got %b/%b/%0d/%0d want 0/0/0/0", blk_a, pnd_a, fc_a, sc_a);
    else pass_cnt++;
    @(posedge clock); #1;
    @(negedge clock);
    total_cnt++;
    if (blk_d !== 1'b0) $display("FAIL sticky_post_reset: got %b want 0", blk_d);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_hold_filter();
    test_unmasked();
    test_legacy_latency();
    test_dropout();
    test_par_mode();
    test_sticky();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_stream_monitor.md
# hls_deadlock_stream_monitor

Parametrised deadlock monitor for one HLS process instance inside the GenerateProof dataflow region. It observes AXI-stream stall lines and child-instance idle/block lines, and asserts `block` after a blocking condition has persisted for a programmable number of cycles. It extends the per-process monitor with a configurable channel count, a persistence filter, sticky latching, first-culprit capture and a stall-duration counter. Its `block` output feeds the parent monitor's sub-instance block inputs.

## Interface
- `N_AXIS`, 8: number of AXI-stream block lines.
- `AXIS_MASK`, `8'h06`: bit i=1 means axis line i is watched. Width `N_AXIS`.
- `N_SUB`, 4: number of child instances (≥1).
- `PAR_MODE`, 0: 1 = children run in parallel (all-blocked rule); 0 = any-blocked rule.
- `HOLD_CYCLES`, 1: consecutive raw-block cycles required before `block` asserts (≥1).
- `STICKY`, 0: 1 = `block` stays set until reset.
- `CNT_W`, 16: stall counter width.
- `CH_W`, `$clog2(N_AXIS+N_SUB)`: culprit index width.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `axis_block_sigs` in `N_AXIS`: per-stream stall indication.
- `sub_idle_sigs` in `N_SUB`: child idle.
- `sub_block_sigs` in `N_SUB`: child `block` outputs.
- `block` out 1: deadlock detected.
- `block_pending` out 1: raw condition present, filter still counting.
- `first_chan` out `CH_W`: culprit index captured at onset.
- `stall_count` out `CNT_W`: cycles spent in BLOCKED, saturating.

## Operation
- `axis_hit` is the OR-reduction of `axis_block_sigs & AXIS_MASK`.
- `sub_hit` depends on `PAR_MODE`:
  - `PAR_MODE=0`: `|sub_block_sigs`.
  - `PAR_MODE=1`: every child is blocked or idle, and at least one child is blocked.
- `raw = axis_hit | sub_hit`.
- FSM states: IDLE, PENDING, BLOCKED. Hold counter `hcnt` has width `$clog2(HOLD_CYCLES+1)`.
  - IDLE, `raw=0`: stay.
  - IDLE, `raw=1`:
    - If `HOLD_CYCLES==1`, go to BLOCKED.
    - Otherwise go to PENDING with `hcnt=1`.
    - In both cases capture `first_chan`.
  - PENDING, `raw=0`: go to IDLE, `hcnt=0`. `first_chan` is retained.
  - PENDING, `raw=1`:
    - If `hcnt==HOLD_CYCLES-1`, go to BLOCKED.
    - Otherwise `hcnt++`.
  - BLOCKED, `raw=0` and `STICKY=0`: go to IDLE.
  - BLOCKED, otherwise: stay.
- Outputs are registered decodes of the state: `block` = (state==BLOCKED), `block_pending` = (state==PENDING).
- `first_chan` selection, in priority order:
  - The lowest watched axis index i with its line set, giving i.
  - Otherwise the lowest child index j with `sub_block_sigs[j]` set, giving `N_AXIS+j`.
  - `first_chan` updates only on the IDLE→(PENDING|BLOCKED) transition.
- `stall_count` increments by 1 in every cycle spent in BLOCKED and saturates at all-ones. It clears only on reset; it is not cleared on return to IDLE, so it accumulates over the run.
- Unmasked axis lines have no effect on any output.

## Timing
- Reset values: state IDLE, `block=0`, `block_pending=0`, `first_chan=0`, `stall_count=0`, `hcnt=0`.
- Reset asserted mid-PENDING or mid-BLOCKED overrides every other input in that cycle.
- Latency: `raw` first high at cycle t and held high gives `block=1` at t+`HOLD_CYCLES`. With `HOLD_CYCLES=1` this is one cycle, identical to the legacy monitor.
- Deassert, `STICKY=0`: `raw` low at cycle t gives `block=0` at t+1.
- A single-cycle `raw` dropout during PENDING restarts the filter from zero.
- `raw` returning high in the same cycle the FSM enters IDLE is sampled on the next edge as a new onset, so `first_chan` is re-captured.
- `stall_count` is visible one cycle after each BLOCKED cycle, so it reads 1 at t+`HOLD_CYCLES`+1.

## Structure
- Package `hls_deadlock_pkg`:
  - state enum `dl_state_e` (IDLE, PENDING, BLOCKED);
  - function `dl_clog2`;
  - constant `DL_SUB_OFFSET` documenting the `N_AXIS+j` index encoding.
- Sub-module `hls_deadlock_prio_enc` (parametrised width, lowest-set-bit index plus valid), instantiated twice: once for masked axis lines, once for child block lines.

## Test plan
- Defaults except `HOLD_CYCLES=4`; hold `axis_block_sigs=8'h04` at t0..t5, then 0 at t6. Required:
  - `block_pending=1` at t1..t3;
  - `block=1` at t4..t6, then 0 at t7;
  - `first_chan=2`;
  - `stall_count=3` at t7.
- Defaults; `axis_block_sigs=8'h01` for 10 cycles. Required: `block`, `block_pending` and `first_chan` stay 0.
- `HOLD_CYCLES=4`; `raw` pattern 1,1,1,0,1,1,1,1. Required: no `block` through the dropout; `block=1` exactly 4 cycles after the second onset.
- `PAR_MODE=1`, `N_SUB=4`, `sub_idle_sigs=4'b0011`:
  - `sub_block_sigs=4'b0100` gives `block=0`;
  - `4'b1100` gives `block=1` next cycle with `first_chan=10`.
- `STICKY=1`; trigger `block`, then drop all inputs. Required: `block` stays 1 and `stall_count` keeps counting. With `CNT_W=4`, `stall_count` saturates at 15. Synchronous `reset` clears all outputs next cycle.
